ldl_sfifo_v2: RTL and testbench

//   Single-clock FIFO with compile-time selectable read mode: first-word-fall-through (AHEAD=1)
//   or registered read (AHEAD=0). Adds an occupancy count, programmable almost-full/almost-empty

---
 rtl/ldl_sfifo_v2.sv | 81 ++++++++
 tb/tb_ldl_sfifo_v2.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ldl_sfifo_v2.sv
// ldl_sfifo_v2: single-clock FIFO, FWFT or registered read, with count, almost flags and error pulses
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   we, din            write request and data, taken when we && ~full
//   re, dout           read request (pop) and read data
//   empty, full        no words / 2**AW words stored
//   afull, aempty      cnt >= AFULL_TH / cnt <= AEMPTY_TH
//   cnt                words stored, 0..2**AW
//   overflow           one-cycle pulse after a write attempted while full
//   underflow          one-cycle pulse after a read attempted while empty
module ldl_sfifo_v2 #(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int AHEAD     = 1,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] din,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          afull,
    output logic          aempty,
    output logic [AW:0]   cnt,
    output logic          overflow,
    output logic          underflow
);
    localparam logic [AW:0] ONE = 1;
    localparam logic [AW:0] AF  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AE  = (AW+1)'(AEMPTY_TH);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wptr, rptr;
    logic          wr_ok, rd_ok;
    logic [DW-1:0] head;

    // No bypass: acceptance depends only on the registered occupancy.
    assign wr_ok  = !rst && we && !full;
    assign rd_ok  = !rst && re && !empty;
    assign empty  = cnt == '0;
    // cnt never exceeds 2**AW, so its top bit alone marks full.
    assign full   = cnt[AW];
    assign afull  = cnt >= AF;
    assign aempty = cnt <= AE;
    assign head   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + ONE;
            if (rd_ok) rptr <= rptr + ONE;
            if (wr_ok && !rd_ok) cnt <= cnt + ONE;
            else if (rd_ok && !wr_ok) cnt <= cnt - ONE;
            overflow  <= we && full;
            underflow <= re && empty;
        end
    end

    if (AHEAD != 0) begin : g_fwft
        // Forced to zero while empty so stale memory never leaks out.
        assign dout = empty ? '0 : head;
    end else begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) dout <= '0;
            else if (rd_ok) dout <= head;
        end
    end
endmodule

// File: tb/tb_ldl_sfifo_v2.sv
// tb_ldl_sfifo_v2: scoreboard bench for both read modes of ldl_sfifo_v2
module tb_ldl_sfifo_v2;
    logic       clk = 0, rst = 1, we = 1, re = 1;
    logic [7:0] din = 0;
    logic [7:0] dout0, dout1;
    logic       empty0, full0, afull0, aempty0, ovf0, udf0;
    logic       empty1, full1, afull1, aempty1, ovf1, udf1;
    logic [4:0] cnt0, cnt1;

    ldl_sfifo_v2 #(.DW(8), .AW(4), .AHEAD(1), .AFULL_TH(14), .AEMPTY_TH(2)) u0 (
        .clk(clk), .rst(rst), .we(we), .din(din), .re(re), .dout(dout0),
        .empty(empty0), .full(full0), .afull(afull0), .aempty(aempty0),
        .cnt(cnt0), .overflow(ovf0), .underflow(udf0));
    ldl_sfifo_v2 #(.DW(8), .AW(4), .AHEAD(0), .AFULL_TH(14), .AEMPTY_TH(2)) u1 (
        .clk(clk), .rst(rst), .we(we), .din(din), .re(re), .dout(dout1),
        .empty(empty1), .full(full1), .afull(afull1), .aempty(aempty1),
        .cnt(cnt1), .overflow(ovf1), .underflow(udf1));

    always #5 clk = ~clk;

    int         n_cmp = 0, n_bad = 0;
    int         mcnt = 0;
    bit         movf = 0, mudf = 0, go = 0;
    logic [7:0] sb0[$], sb1[$];
    logic [7:0] exp1 = 0, d = 8'ha1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: occupancy and the stream of accepted words.
    always @(posedge clk) begin
        if (rst) begin
            mcnt = 0;
            movf = 0;
            mudf = 0;
        end else begin
            bit wa, ra;
            wa   = we && mcnt < 16;
            ra   = re && mcnt > 0;
            movf = we && mcnt == 16;
            mudf = re && mcnt == 0;
            if (wa) begin
                sb0.push_back(din);
                sb1.push_back(din);
            end
            mcnt = mcnt + int'(wa) - int'(ra);
        end
    end

    // Monitor: status against the model, data popped from the scoreboards.
    always @(negedge clk) begin
        if (go) begin
            chk("cnt0", cnt0, mcnt);
            chk("empty0", empty0, mcnt == 0);
            chk("full0", full0, mcnt == 16);
            chk("afull0", afull0, mcnt >= 14);
            chk("aempty0", aempty0, mcnt <= 2);
            chk("ovf0", ovf0, movf);
            chk("udf0", udf0, mudf);
            chk("cnt1", cnt1, mcnt);
            chk("empty1", empty1, mcnt == 0);
            chk("full1", full1, mcnt == 16);
            chk("afull1", afull1, mcnt >= 14);
            chk("aempty1", aempty1, mcnt <= 2);
            chk("ovf1", ovf1, movf);
            chk("udf1", udf1, mudf);
            chk("dout1", dout1, exp1);
            if (rst) begin
                sb0.delete();
                sb1.delete();
                exp1 = 0;
            end else if (re) begin
                if (!empty0) begin
                    if (sb0.size() == 0) chk("sb0_extra_read", 1, 0);
                    else chk("dout0", dout0, sb0.pop_front());
                end
                if (!empty1) begin
                    if (sb1.size() == 0) chk("sb1_extra_read", 1, 0);
                    else exp1 = sb1.pop_front();
                end
            end
        end
    end

    task automatic cyc(input bit r, input bit w, input bit rd);
        rst = r;
        we  = w;
        re  = rd;
        din = d;
        if (w) d++;
        @(posedge clk);
        #1;
    endtask

    task automatic level(input int n);
        while (mcnt < n) cyc(0, 1, 0);
        while (mcnt > n) cyc(0, 0, 1);
    endtask

    initial begin
        cyc(1, 1, 1);
        cyc(1, 1, 1);
        go = 1;
        chk("rst_dout0", dout0, 0);
        chk("rst_dout1", dout1, 0);
        d = 8'ha1;
        for (int i = 0; i < 20; i++) cyc(0, 1, 0);
        chk("fill_dout0", dout0, 8'ha1);
        for (int i = 0; i < 17; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        d = 8'ha1;
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        level(5);
        for (int i = 0; i < 30; i++) cyc(0, 1, 1);
        level(16);
        cyc(0, 1, 1);
        cyc(0, 0, 0);
        level(0);
        cyc(0, 1, 1);
        cyc(0, 0, 0);
        level(7);
        cyc(1, 0, 0);
        d = 8'h55;
        cyc(0, 1, 0);
        chk("post_rst_head", dout0, 8'h55);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            int pw;
            pw = ((i / 64) % 2 == 0) ? 75 : 25;
            d  = 8'($urandom);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) < pw,
                $urandom_range(0, 99) >= pw - 10);
        end
        cyc(0, 0, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
